hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS32 core; companion to the forwarding unit. It detects load-use hazards that forwarding cannot resolve and sequences multi-cycle mul/div stalls with a timeout. It also issues branch flushes by driving the pipeline-register enables and flushes. It sits beside stage 2 (decode) and stage 3 (execute) and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_stall_ctrl_if.sv | 43 ++++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: decode/execute hazard inputs and pipeline-control outputs
// exchanged between the core datapath (master) and the hazard/stall controller (slave).
`default_nettype none

interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             mem_read_f3;
  logic [4:0]       escrita_f3;
  logic [4:0]       RS_f2;
  logic [4:0]       RT_f2;
  logic             usa_rt_f2;
  logic             muldiv_start_f3;
  logic             muldiv_done;
  logic             branch_taken_f3;
  logic             pc_enable;
  logic             if_id_enable;
  logic             id_ex_enable;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       estado;
  logic             erro;
  logic [CNT_W-1:0] ciclos_stall;

  modport master (
    output mem_read_f3, escrita_f3, RS_f2, RT_f2, usa_rt_f2,
           muldiv_start_f3, muldiv_done, branch_taken_f3,
    input  pc_enable, if_id_enable, id_ex_enable,
           if_id_flush, id_ex_flush, ex_mem_flush,
           estado, erro, ciclos_stall
  );

  modport slave (
    input  mem_read_f3, escrita_f3, RS_f2, RT_f2, usa_rt_f2,
           muldiv_start_f3, muldiv_done, branch_taken_f3,
    output pc_enable, if_id_enable, id_ex_enable,
           if_id_flush, id_ex_flush, ex_mem_flush,
           estado, erro, ciclos_stall
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, mul/div wait sequencing with timeout, branch flush,
// and a saturating stall-cycle counter for the 5-stage MIPS32 pipeline. Rev 1.0
`default_nettype none

module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 32,
  parameter int CNT_W    = 16
) (
  input  wire                 clock,
  input  wire                 reset_n,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WAIT = 2'b01,
    S_ERRO = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WAIT_W-1:0]  r_wcnt;
  logic [WAIT_W-1:0]  w_wcnt_next;
  logic               r_erro;
  logic               w_set_erro;
  logic [CNT_W-1:0]   r_cnt;

  logic w_hz;
  logic w_pc_en, w_if_id_en, w_id_ex_en;
  logic w_if_id_fl, w_id_ex_fl, w_ex_mem_fl;

  assign w_hz = bus.mem_read_f3 && (bus.escrita_f3 != 5'd0) &&
                ((bus.escrita_f3 == bus.RS_f2) ||
                 (bus.usa_rt_f2 && (bus.escrita_f3 == bus.RT_f2)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
      r_wcnt  <= '0;
      r_erro  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_set_erro)
        r_erro <= 1'b1;
      if (!w_pc_en && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Mealy outputs: stalls must take effect on the same edge the hazard is seen.
  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_set_erro   = 1'b0;
    w_pc_en      = 1'b1;
    w_if_id_en   = 1'b1;
    w_id_ex_en   = 1'b1;
    w_if_id_fl   = 1'b0;
    w_id_ex_fl   = 1'b0;
    w_ex_mem_fl  = 1'b0;

    if (!reset_n) begin
      w_state_next = S_RUN;
      w_wcnt_next  = '0;
      w_pc_en      = 1'b0;
      w_if_id_en   = 1'b0;
      w_id_ex_en   = 1'b0;
      w_if_id_fl   = 1'b1;
      w_id_ex_fl   = 1'b1;
      w_ex_mem_fl  = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.branch_taken_f3) begin
            w_if_id_fl = 1'b1;
            w_id_ex_fl = 1'b1;
          end else if (bus.muldiv_start_f3) begin
            w_state_next = S_WAIT;
            w_wcnt_next  = '0;
          end else if (w_hz) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_id_ex_fl = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.muldiv_done) begin
            w_state_next = S_RUN;
          end else begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_fl = 1'b1;
            w_wcnt_next = r_wcnt + WAIT_W'(1);
            if (r_wcnt == WAIT_W'(MAX_WAIT - 1)) begin
              w_state_next = S_ERRO;
              w_set_erro   = 1'b1;
            end
          end
        end
        S_ERRO:  w_state_next = S_RUN;
        default: w_state_next = S_RUN;
      endcase
    end
  end

  assign bus.pc_enable    = w_pc_en;
  assign bus.if_id_enable = w_if_id_en;
  assign bus.id_ex_enable = w_id_ex_en;
  assign bus.if_id_flush  = w_if_id_fl;
  assign bus.id_ex_flush  = w_id_ex_fl;
  assign bus.ex_mem_flush = w_ex_mem_fl;
  assign bus.estado       = r_state;
  assign bus.erro         = r_erro;
  assign bus.ciclos_stall = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with hand-computed expectations for hazard_stall_ctrl.
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 6;
  localparam int CNT_W    = 4;

  // Control-output packing: {pc_en, if_id_en, id_ex_en, if_id_fl, id_ex_fl, ex_mem_fl}
  localparam logic [5:0] O_RST   = 6'b000111;
  localparam logic [5:0] O_DEF   = 6'b111000;
  localparam logic [5:0] O_LOAD  = 6'b001010;
  localparam logic [5:0] O_BR    = 6'b111110;
  localparam logic [5:0] O_MDW   = 6'b000001;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.pc_enable, bus.if_id_enable, bus.id_ex_enable,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.mem_read_f3     = 1'b0;
    bus.escrita_f3      = 5'd0;
    bus.RS_f2           = 5'd0;
    bus.RT_f2           = 5'd0;
    bus.usa_rt_f2       = 1'b0;
    bus.muldiv_start_f3 = 1'b0;
    bus.muldiv_done     = 1'b0;
    bus.branch_taken_f3 = 1'b0;
  endtask

  task automatic set_hz(input logic [4:0] esc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic usa_rt);
    bus.mem_read_f3 = 1'b1;
    bus.escrita_f3  = esc;
    bus.RS_f2       = rs;
    bus.RT_f2       = rt;
    bus.usa_rt_f2   = usa_rt;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_in();
    rst_n = 1'b0;
    #2;
    check_eq("rst_outs", 32'(outs()), 32'(O_RST));
    check_eq("rst_estado", 32'(bus.estado), 32'd0);
    check_eq("rst_erro", 32'(bus.erro), 32'd0);
    check_eq("rst_cnt", 32'(bus.ciclos_stall), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_outs", 32'(outs()), 32'(O_DEF));

    // Load-use on RS: exactly one stall, then the bubble clears the hazard.
    cyc();
    set_hz(5'd4, 5'd4, 5'd7, 1'b0);
    #1 check_eq("lu_rs_outs", 32'(outs()), 32'(O_LOAD));
    cyc();
    clear_in();
    #1 check_eq("lu_after_outs", 32'(outs()), 32'(O_DEF));
    check_eq("lu_cnt", 32'(bus.ciclos_stall), 32'd1);

    // RT match only counts when RT is read; r0 never hazards.
    set_hz(5'd4, 5'd5, 5'd4, 1'b0);
    #1 check_eq("rt_unused", 32'(outs()), 32'(O_DEF));
    bus.usa_rt_f2 = 1'b1;
    #1 check_eq("rt_used", 32'(outs()), 32'(O_LOAD));
    set_hz(5'd0, 5'd0, 5'd0, 1'b1);
    #1 check_eq("r0_nohz", 32'(outs()), 32'(O_DEF));
    bus.mem_read_f3 = 1'b0;
    bus.escrita_f3  = 5'd9;
    bus.RS_f2       = 5'd9;
    #1 check_eq("noload_nohz", 32'(outs()), 32'(O_DEF));
    clear_in();
    cyc();
    check_eq("rt_cnt_unchanged", 32'(bus.ciclos_stall), 32'd1);

    // Branch wins over load-use; stall counter must not move.
    set_hz(5'd4, 5'd4, 5'd0, 1'b0);
    bus.branch_taken_f3 = 1'b1;
    #1 check_eq("br_hz_outs", 32'(outs()), 32'(O_BR));
    cyc();
    clear_in();
    check_eq("br_cnt", 32'(bus.ciclos_stall), 32'd1);
    bus.branch_taken_f3 = 1'b1;
    bus.muldiv_start_f3 = 1'b1;
    #1 check_eq("br_md_outs", 32'(outs()), 32'(O_BR));
    cyc();
    clear_in();
    check_eq("br_md_estado", 32'(bus.estado), 32'd0);

    // done in RUN is ignored.
    bus.muldiv_done = 1'b1;
    #1 check_eq("done_run_outs", 32'(outs()), 32'(O_DEF));
    cyc();
    clear_in();
    check_eq("done_run_estado", 32'(bus.estado), 32'd0);

    // Mul/div done on the 5th cycle after start -> 4 stall cycles.
    do_reset();
    bus.muldiv_start_f3 = 1'b1;
    #1 check_eq("md_start_outs", 32'(outs()), 32'(O_DEF));
    cyc();
    clear_in();
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        set_hz(5'd3, 5'd3, 5'd0, 1'b0);
        bus.branch_taken_f3 = 1'b1;
      end
      #1 check_eq($sformatf("md_wait%0d_outs", k), 32'(outs()), 32'(O_MDW));
      check_eq($sformatf("md_wait%0d_estado", k), 32'(bus.estado), 32'd1);
      cyc();
      clear_in();
    end
    bus.muldiv_done = 1'b1;
    #1 check_eq("md_done_outs", 32'(outs()), 32'(O_DEF));
    check_eq("md_done_estado", 32'(bus.estado), 32'd1);
    cyc();
    clear_in();
    check_eq("md_end_estado", 32'(bus.estado), 32'd0);
    check_eq("md_cnt", 32'(bus.ciclos_stall), 32'd4);
    check_eq("md_erro", 32'(bus.erro), 32'd0);

    // Timeout: MAX_WAIT stall cycles, one ERRO cycle, sticky erro.
    do_reset();
    bus.muldiv_start_f3 = 1'b1;
    cyc();
    clear_in();
    for (int k = 1; k <= MAX_WAIT; k++) begin
      #1 check_eq($sformatf("to_wait%0d_outs", k), 32'(outs()), 32'(O_MDW));
      cyc();
    end
    check_eq("to_erro_estado", 32'(bus.estado), 32'd2);
    check_eq("to_erro_outs", 32'(outs()), 32'(O_DEF));
    check_eq("to_erro_flag", 32'(bus.erro), 32'd1);
    check_eq("to_cnt", 32'(bus.ciclos_stall), 32'(MAX_WAIT));
    cyc();
    check_eq("to_run_estado", 32'(bus.estado), 32'd0);
    cyc();
    cyc();
    check_eq("to_erro_sticky", 32'(bus.erro), 32'd1);
    do_reset();
    check_eq("to_erro_cleared", 32'(bus.erro), 32'd0);

    // Saturation: 20 consecutive load-use stalls with a 4-bit counter.
    set_hz(5'd8, 5'd8, 5'd0, 1'b0);
    for (int k = 0; k < 14; k++) cyc();
    check_eq("sat_cnt14", 32'(bus.ciclos_stall), 32'd14);
    for (int k = 0; k < 6; k++) cyc();
    check_eq("sat_cnt20", 32'(bus.ciclos_stall), 32'd15);
    clear_in();

    // Asynchronous reset in the middle of a mul/div wait.
    do_reset();
    bus.muldiv_start_f3 = 1'b1;
    cyc();
    clear_in();
    cyc();
    check_eq("ar_pre_estado", 32'(bus.estado), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_eq("ar_outs", 32'(outs()), 32'(O_RST));
    check_eq("ar_estado", 32'(bus.estado), 32'd0);
    check_eq("ar_cnt", 32'(bus.ciclos_stall), 32'd0);
    check_eq("ar_erro", 32'(bus.erro), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1 check_eq("ar_release_outs", 32'(outs()), 32'(O_DEF));
    cyc();
    check_eq("ar_release_estado", 32'(bus.estado), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
